lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci LFSR pattern generator; the general-purpose successor to the fixed 6-bit LED LFSR. Width, tap mask, seed and step rate are parameters. The block runs entirely on the system clock, using an internal prescaler clock-enable instead of a derived clock. Runtime seed load, all-zero lock-up recovery and period measurement support LED demos, test-pattern sources and self-checking benches.

## Interface
- `WIDTH`, 6: LFSR length in bits, 2..32.
- `TAPS`, 6'b100001: feedback mask, WIDTH bits; bit i set means state[i] is XORed into the feedback. TAPS[WIDTH-1] must be 1.
- `SEED`, all ones: reset and recovery value, WIDTH bits, must be nonzero.
- `DIV`, 1: prescaler period in clk cycles, 1..2^24. At DIV=1 the register steps every enabled cycle.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: run enable; gates both the prescaler and stepping.
- `load` in 1: single-cycle seed load strobe.
- `load_val` in WIDTH: value written on `load`.
- `state` out WIDTH: current LFSR register.
- `step` out 1: one-cycle pulse, high in the cycle after `state` advanced.
- `wrap` out 1: one-cycle pulse when a step returns `state` to the current reference seed.
- `period` out 32: number of steps between the last two reference-seed hits. Saturates at all ones.
- `lockup` out 1: sticky flag for an all-zero condition. Cleared by `rst` or by a `load` of a nonzero value.

## Operation
- Step rule: fb = XOR over i of (state[i] & TAPS[i]). Next state = {state[WIDTH-2:0], fb}. New bit enters bit 0 and the register shifts toward the MSB.
- Reference seed: the register holding the value `wrap` compares against. Set to SEED at reset; updated to `load_val` (or SEED if `load_val`=0) on every `load`.
- Prescaler: counter `div_cnt` runs 0..DIV-1 while `en`=1, holds while `en`=0. The internal tick fires when `div_cnt`=DIV-1 and `en`=1; `div_cnt` then returns to 0.
- Priority per cycle: `rst` > `load` > tick step.
- On `load`:
  - `state` <= `load_val`, `div_cnt` <= 0, step counter <= 0.
  - If `load_val`=0, load SEED instead and set `lockup`.
  - No `step` or `wrap` pulse is produced on a load cycle.
- On tick with state≠0: apply the step rule and increment the step counter (saturating).
  - If the next state equals the reference seed: pulse `wrap`, latch the incremented count into `period`, and clear the step counter.
- On tick with state=0 (only reachable through a corrupted register): load SEED, set `lockup`, and no `wrap`.
- Non-maximal TAPS is allowed. `period` then reports the actual cycle length from the seed.

## Timing
- Reset values:
  - `state`=SEED, reference seed=SEED
  - `div_cnt`=0, step counter=0
  - `period`=0, `step`=0, `wrap`=0, `lockup`=0
- All outputs are registered. `state` changes on the clk edge that samples the tick. `step` and `wrap` are high for exactly the following cycle, coincident with the new `state`.
- Load latency: 1 cycle; `state`=`load_val` on the cycle after `load` is sampled high.
- After `load` or after `en` rises, the first step occurs DIV enabled cycles later.
- `rst` asserted mid-count: every register returns to its reset value immediately and asynchronously. Release is synchronous to clk.
- Step counter at saturation (2^32-1): it holds; `period` then reads all ones.

## Structure
- Package `lfsr_pkg`:
  - `lfsr_taps(width)`: constant function returning a maximal tap mask for widths 2..32.
  - Localparam default for the 6-bit demo mask, 6'b100001.
- Sub-module `tick_div #(DIV)`: clk, rst, en → `tick` pulse. Reused by the board-top wrapper, with DIV=2^22 for visible LED stepping.
- `lfsr_gen` contains the shift register, the reference-seed compare, the step/period counter and the lock-up logic.

## Test plan
- Reset with WIDTH=6, TAPS=6'b100001, SEED=6'h3F, DIV=1, `en`=1. Expected: `state` sequence 111111 → 111110 → 111101 → 111010, with one `step` pulse per cycle.
- Run the same configuration for 63 steps. Expected: `state`=111111, `wrap` pulses once, `period`=63, and no repeated state inside the cycle.
- DIV=4 with `en` toggled low for 3 cycles mid-count. Expected: steps are exactly 4 enabled cycles apart and the prescaler count holds while `en`=0.
- `load` with `load_val`=6'h15 asserted on the same cycle as a tick. Expected: next `state`=010101, no `step` pulse, and `wrap` fires 63 steps later with `period`=63.
- `load` with `load_val`=0. Expected: `state`=SEED and `lockup`=1. A following `load` of 6'h01 clears `lockup`.
- Assert `rst` asynchronously between clk edges mid-run. Expected: `state`=SEED and `period`=0 immediately, and stepping resumes DIV cycles after release.

Source files
------------

// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for the LFSR pattern generator: maximal feedback masks
// for every supported register length and the 6-bit demo defaults.
package lfsr_pkg;

  localparam int          LFSR_MIN_WIDTH = 2;
  localparam int          LFSR_MAX_WIDTH = 32;
  localparam logic [5:0]  LFSR_DEMO_TAPS = 6'b100001;
  localparam int          LFSR_CNT_W     = 32;

  // Masks come from primitive trinomials/pentanomials; bit i selects state[i].
  // Width 6 returns the demo mask so the default build matches the LED board.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] mask;
    case (width)
      2:  mask = 32'h0000_0003;
      3:  mask = 32'h0000_0006;
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'(LFSR_DEMO_TAPS);
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_D008;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_gen_tick_div.sv
// Prescaler clock-enable: emits a one-cycle tick every DIV enabled cycles,
// holding its count while en is low. clr restarts the count from zero.
module tick_div
  import lfsr_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign tick = en && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pattern generator with seed load, all-zero recovery and
// measurement of the step count between successive reference-seed hits.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      state,
  output logic                  step,
  output logic                  wrap,
  output logic [LFSR_CNT_W-1:0] period,
  output logic                  lockup
);

  logic                  tick;

  logic [WIDTH-1:0]      state_q,  state_d;
  logic [WIDTH-1:0]      ref_q,    ref_d;
  logic [LFSR_CNT_W-1:0] cnt_q,    cnt_d;
  logic [LFSR_CNT_W-1:0] period_q, period_d;
  logic                  step_q,   step_d;
  logic                  wrap_q,   wrap_d;
  logic                  lockup_q, lockup_d;

  logic                  fb;
  logic [WIDTH-1:0]      shifted;
  logic [WIDTH-1:0]      load_eff;
  logic [LFSR_CNT_W-1:0] cnt_inc;

  // The prescaler restarts on load so the first step lands DIV enabled cycles later.
  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign fb       = ^(state_q & TAPS);
  assign shifted  = {state_q[WIDTH-2:0], fb};
  assign load_eff = (load_val == '0) ? SEED : load_val;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = lockup_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;

    if (load) begin
      state_d  = load_eff;
      ref_d    = load_eff;
      cnt_d    = '0;
      lockup_d = (load_val == '0);
    end else if (tick) begin
      step_d = 1'b1;
      if (state_q == '0) begin
        // Only a corrupted register gets here; reseed rather than stall forever.
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = shifted;
        if (shifted == ref_q) begin
          wrap_d   = 1'b1;
          period_d = cnt_inc;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign state  = state_q;
  assign step   = step_q;
  assign wrap   = wrap_q;
  assign period = period_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: one instance at DIV=1 and one at DIV=4,
// sharing clock and reset, checked against hand-computed vectors.
module tb_lfsr_gen;

  typedef struct {
    logic       en;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] exp_state;
    logic       exp_step;
    logic       exp_wrap;
    logic       exp_lockup;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        en_a = 1'b0, load_a = 1'b0;
  logic [5:0]  load_val_a = 6'h00;
  logic [5:0]  state_a;
  logic        step_a, wrap_a, lockup_a;
  logic [31:0] period_a;

  logic        en_b = 1'b0, load_b = 1'b0;
  logic [5:0]  load_val_b = 6'h00;
  logic [5:0]  state_b;
  logic        step_b, wrap_b, lockup_b;
  logic [31:0] period_b;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t va[12];
  vec_t vb[17];
  bit   seen[64];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(6), .TAPS(6'b100001), .SEED(6'h3F), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .load_val(load_val_a),
    .state(state_a), .step(step_a), .wrap(wrap_a), .period(period_a), .lockup(lockup_a)
  );

  lfsr_gen #(.WIDTH(6), .TAPS(6'b100001), .SEED(6'h3F), .DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .load_val(load_val_b),
    .state(state_b), .step(step_b), .wrap(wrap_b), .period(period_b), .lockup(lockup_b)
  );

  function automatic logic [5:0] nxt(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input bit sel_b, input int idx);
    if (sel_b) begin
      en_b = v.en; load_b = v.load; load_val_b = v.load_val;
    end else begin
      en_a = v.en; load_a = v.load; load_val_a = v.load_val;
    end
    @(posedge clk);
    #1;
    if (sel_b) begin
      $display("B[%0d] en=%b load=%b val=%h -> state=%h step=%b", idx, v.en, v.load, v.load_val, state_b, step_b);
      check("b_state", 32'(state_b), 32'(v.exp_state));
      check("b_step", 32'(step_b), 32'(v.exp_step));
      check("b_wrap", 32'(wrap_b), 32'(v.exp_wrap));
      check("b_lockup", 32'(lockup_b), 32'(v.exp_lockup));
    end else begin
      $display("A[%0d] en=%b load=%b val=%h -> state=%h step=%b lockup=%b", idx, v.en, v.load, v.load_val, state_a, step_a, lockup_a);
      check("a_state", 32'(state_a), 32'(v.exp_state));
      check("a_step", 32'(step_a), 32'(v.exp_step));
      check("a_wrap", 32'(wrap_a), 32'(v.exp_wrap));
      check("a_lockup", 32'(lockup_a), 32'(v.exp_lockup));
    end
  endtask

  // Run 63 steps on instance A from start value s0; wrap only on the last one.
  task automatic run_cycle(input logic [5:0] s0, input string tag);
    logic [5:0] exp_s;
    exp_s = s0;
    foreach (seen[k]) seen[k] = 1'b0;
    seen[s0] = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      @(posedge clk);
      #1;
      exp_s = nxt(exp_s);
      check({tag, "_state"}, 32'(state_a), 32'(exp_s));
      check({tag, "_step"}, 32'(step_a), 32'd1);
      check({tag, "_wrap"}, 32'(wrap_a), (i == 63) ? 32'd1 : 32'd0);
      if (i < 63) begin
        check({tag, "_no_repeat"}, 32'(seen[state_a]), 32'd0);
        seen[state_a] = 1'b1;
      end
    end
    check({tag, "_period"}, period_a, 32'd63);
    $display("%s: 63 steps done, state=%h period=%0d", tag, state_a, period_a);
  endtask

  initial begin
    //          en    load  val     state  step  wrap  lock
    va[0]  = '{1'b1, 1'b0, 6'h00, 6'h3E, 1'b1, 1'b0, 1'b0};
    va[1]  = '{1'b1, 1'b0, 6'h00, 6'h3D, 1'b1, 1'b0, 1'b0};
    va[2]  = '{1'b1, 1'b0, 6'h00, 6'h3A, 1'b1, 1'b0, 1'b0};
    va[3]  = '{1'b0, 1'b0, 6'h00, 6'h3A, 1'b0, 1'b0, 1'b0};
    va[4]  = '{1'b1, 1'b0, 6'h00, 6'h35, 1'b1, 1'b0, 1'b0};
    va[5]  = '{1'b1, 1'b1, 6'h15, 6'h15, 1'b0, 1'b0, 1'b0};
    va[6]  = '{1'b1, 1'b0, 6'h00, 6'h2B, 1'b1, 1'b0, 1'b0};
    va[7]  = '{1'b1, 1'b1, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b1};
    va[8]  = '{1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b1};
    va[9]  = '{1'b0, 1'b1, 6'h01, 6'h01, 1'b0, 1'b0, 1'b0};
    va[10] = '{1'b1, 1'b0, 6'h00, 6'h03, 1'b1, 1'b0, 1'b0};
    va[11] = '{1'b1, 1'b0, 6'h00, 6'h07, 1'b1, 1'b0, 1'b0};

    vb[0]  = '{1'b1, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0};
    vb[1]  = '{1'b1, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0};
    vb[2]  = '{1'b1, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0};
    vb[3]  = '{1'b1, 1'b0, 6'h00, 6'h3E, 1'b1, 1'b0, 1'b0};
    vb[4]  = '{1'b1, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[5]  = '{1'b1, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[6]  = '{1'b0, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[7]  = '{1'b0, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[8]  = '{1'b0, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[9]  = '{1'b1, 1'b0, 6'h00, 6'h3E, 1'b0, 1'b0, 1'b0};
    vb[10] = '{1'b1, 1'b0, 6'h00, 6'h3D, 1'b1, 1'b0, 1'b0};
    vb[11] = '{1'b1, 1'b0, 6'h00, 6'h3D, 1'b0, 1'b0, 1'b0};
    vb[12] = '{1'b1, 1'b1, 6'h15, 6'h15, 1'b0, 1'b0, 1'b0};
    vb[13] = '{1'b1, 1'b0, 6'h00, 6'h15, 1'b0, 1'b0, 1'b0};
    vb[14] = '{1'b1, 1'b0, 6'h00, 6'h15, 1'b0, 1'b0, 1'b0};
    vb[15] = '{1'b1, 1'b0, 6'h00, 6'h15, 1'b0, 1'b0, 1'b0};
    vb[16] = '{1'b1, 1'b0, 6'h00, 6'h2B, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    $display("reset: state=%h period=%0d step=%b wrap=%b lockup=%b", state_a, period_a, step_a, wrap_a, lockup_a);
    check("rst_state", 32'(state_a), 32'h3F);
    check("rst_period", period_a, 32'd0);
    check("rst_step", 32'(step_a), 32'd0);
    check("rst_wrap", 32'(wrap_a), 32'd0);
    check("rst_lockup", 32'(lockup_a), 32'd0);
    check("rst_state_b", 32'(state_b), 32'h3F);
    rst = 1'b0;

    // Table A: first steps, en gating, load on a tick, zero load / lockup clear
    for (int i = 0; i < 12; i++) apply_row(va[i], 1'b0, i);

    // Load 0x15 and run a full cycle back to it
    en_a = 1'b1; load_a = 1'b1; load_val_a = 6'h15;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    $display("load 15: state=%h step=%b", state_a, step_a);
    check("ld15_state", 32'(state_a), 32'h15);
    check("ld15_step", 32'(step_a), 32'd0);
    run_cycle(6'h15, "cyc15");

    // Asynchronous reset between clock edges mid-run
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    $display("async rst: state=%h period=%0d step=%b", state_a, period_a, step_a);
    check("arst_state", 32'(state_a), 32'h3F);
    check("arst_period", period_a, 32'd0);
    check("arst_step", 32'(step_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycle(6'h3F, "cyc3f");
    en_a = 1'b0;

    // Table B: DIV=4 spacing, en held low mid-count, load restarts the prescaler
    for (int i = 0; i < 17; i++) apply_row(vb[i], 1'b1, i);
    en_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
